// File: rtl/csr_axi_pkg.sv
// ============================================================================
// Module      : csr_axi_pkg
// Description : Shared constants, FSM state types and helpers for the
//               AXI4 CSR slave (csr_axi_slave / csr_regarray).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_axi_pkg;

    // AXI burst type codes
    localparam logic [1:0] FIXED     = 2'b00;
    localparam logic [1:0] INCR      = 2'b01;
    localparam logic [1:0] WRAP      = 2'b10;

    // AXI response codes
    localparam logic [1:0] OKAY      = 2'b00;
    localparam logic [1:0] SLVERR    = 2'b10;

    // Only full 32-bit beats are supported
    localparam logic [2:0] SIZE_WORD = 3'b010;

    // Register file geometry
    localparam int         NUM_REGS  = 32;
    localparam int         IDX_W     = 5;

    // Write-side FSM
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Read-side FSM
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Register index of the next beat: INCR wraps modulo 32, anything else holds
    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                    input logic [1:0]       burst);
        return (burst == INCR) ? idx + 5'd1 : idx;
    endfunction

    // A burst is unsupported unless it is FIXED/INCR with word-sized beats
    function automatic logic burst_illegal(input logic [1:0] burst,
                                           input logic [2:0] size);
        return ((burst != FIXED) && (burst != INCR)) || (size != SIZE_WORD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_regarray.sv
// ============================================================================
// Module      : csr_regarray
// Description : 32 x 32-bit register array with one byte-enabled synchronous
//               write port and one registered read port. Entry 0 reads as 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_regarray
    import csr_axi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [NUM_REGS];
    logic [31:0] rdata_q;

    // Storage: byte-lane writes; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read port: captures pre-write contents on a same-edge collision and
    // holds its value between read enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (raddr_i == '0) ? 32'd0 : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/csr_axi_slave.sv
// ============================================================================
// Module      : csr_axi_slave
// Description : AXI4 slave exposing 32 x 32-bit CSRs with independent write
//               and read engines, INCR/FIXED bursts, byte strobes and a
//               post-reset busy window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_axi_slave
    import csr_axi_pkg::*;
#(
    parameter int ID_W        = 5,
    parameter int INIT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    // AW channel
    input  logic            s_axi_awvalid,
    input  logic [4:0]      s_axi_awaddr,
    input  logic [ID_W-1:0] s_axi_awid,
    input  logic [7:0]      s_axi_awlen,
    input  logic [2:0]      s_axi_awsize,
    input  logic [1:0]      s_axi_awburst,
    output logic            s_axi_awready,
    // W channel
    input  logic            s_axi_wvalid,
    input  logic [31:0]     s_axi_wdata,
    input  logic [3:0]      s_axi_wstrb,
    input  logic            s_axi_wlast,
    output logic            s_axi_wready,
    // B channel
    output logic            s_axi_bvalid,
    output logic [ID_W-1:0] s_axi_bid,
    output logic [1:0]      s_axi_bresp,
    input  logic            s_axi_bready,
    // AR channel
    input  logic            s_axi_arvalid,
    input  logic [4:0]      s_axi_araddr,
    input  logic [ID_W-1:0] s_axi_arid,
    input  logic [7:0]      s_axi_arlen,
    input  logic [2:0]      s_axi_arsize,
    input  logic [1:0]      s_axi_arburst,
    output logic            s_axi_arready,
    // R channel
    output logic            s_axi_rvalid,
    output logic [31:0]     s_axi_rdata,
    output logic [ID_W-1:0] s_axi_rid,
    output logic [1:0]      s_axi_rresp,
    output logic            s_axi_rlast,
    input  logic            s_axi_rready,
    // Init status
    output logic            rsta_busy,
    output logic            rstb_busy
);

    // Counter only needs to reach INIT_CYCLES-1
    localparam int               CNT_W     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = (INIT_CYCLES > 0) ? CNT_W'(INIT_CYCLES - 1) : '0;
    // Write beat counter saturates so runaway bursts still flag a length error
    localparam logic [8:0]       BEAT_SAT  = 9'h1FF;

    // ------------------------------------------------------------------
    // Post-reset busy window
    // ------------------------------------------------------------------
    logic             busy_q;
    logic [CNT_W-1:0] init_cnt_q;

    // Busy stays high for exactly INIT_CYCLES rising edges after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b1;
            init_cnt_q <= '0;
        end else if (busy_q) begin
            init_cnt_q <= init_cnt_q + CNT_W'(1);
            busy_q     <= (init_cnt_q != LAST_CNT);
        end
    end

    assign rsta_busy = busy_q;
    assign rstb_busy = busy_q;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_e        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] widx_q,     widx_d;
    logic [ID_W-1:0]  wid_q,      wid_d;
    logic [7:0]       wlen_q,     wlen_d;
    logic [1:0]       wburst_q,   wburst_d;
    logic             werr_q,     werr_d;
    logic [8:0]       wbeat_q,    wbeat_d;
    logic [1:0]       bresp_q,    bresp_d;
    logic             aw_hs;
    logic             w_hs;
    logic             wr_en;

    assign s_axi_awready = (wr_state_q == W_IDLE) && !busy_q;
    assign s_axi_wready  = (wr_state_q == W_DATA) && !busy_q;
    assign s_axi_bvalid  = (wr_state_q == W_RESP);
    assign s_axi_bid     = wid_q;
    assign s_axi_bresp   = bresp_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;

    // Write FSM next state: latch AW, write beats, then hold the response
    always_comb begin
        wr_state_d = wr_state_q;
        widx_d     = widx_q;
        wid_d      = wid_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        werr_d     = werr_q;
        wbeat_d    = wbeat_q;
        bresp_d    = bresp_q;
        wr_en      = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    widx_d     = s_axi_awaddr;
                    wid_d      = s_axi_awid;
                    wlen_d     = s_axi_awlen;
                    wburst_d   = s_axi_awburst;
                    werr_d     = burst_illegal(s_axi_awburst, s_axi_awsize);
                    wbeat_d    = '0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // Illegal bursts are drained without touching storage
                    wr_en  = !werr_q;
                    widx_d = next_index(widx_q, wburst_q);
                    if (wbeat_q != BEAT_SAT) begin
                        wbeat_d = wbeat_q + 9'd1;
                    end
                    if (s_axi_wlast) begin
                        bresp_d    = (werr_q || (wbeat_q != {1'b0, wlen_q})) ? SLVERR : OKAY;
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase
    end

    // Write FSM state and burst context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            widx_q     <= '0;
            wid_q      <= '0;
            wlen_q     <= '0;
            wburst_q   <= FIXED;
            werr_q     <= 1'b0;
            wbeat_q    <= '0;
            bresp_q    <= OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            widx_q     <= widx_d;
            wid_q      <= wid_d;
            wlen_q     <= wlen_d;
            wburst_q   <= wburst_d;
            werr_q     <= werr_d;
            wbeat_q    <= wbeat_d;
            bresp_q    <= bresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_e        rd_state_q, rd_state_d;
    logic [IDX_W-1:0] ridx_q,     ridx_d;
    logic [ID_W-1:0]  rid_q,      rid_d;
    logic [7:0]       rlen_q,     rlen_d;
    logic [1:0]       rburst_q,   rburst_d;
    logic             rerr_q,     rerr_d;
    logic [7:0]       rbeat_q,    rbeat_d;
    logic             ar_hs;
    logic             r_hs;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [31:0]      rd_data;

    assign s_axi_arready = (rd_state_q == R_IDLE) && !busy_q;
    assign s_axi_rvalid  = (rd_state_q == R_DATA);
    assign s_axi_rlast   = s_axi_rvalid && (rbeat_q == rlen_q);
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rerr_q ? SLVERR : OKAY;
    assign s_axi_rdata   = rerr_q ? 32'd0 : rd_data;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

    // Read FSM next state: prefetch each beat on the handshake that frees the bus
    always_comb begin
        rd_state_d = rd_state_q;
        ridx_d     = ridx_q;
        rid_d      = rid_q;
        rlen_d     = rlen_q;
        rburst_d   = rburst_q;
        rerr_d     = rerr_q;
        rbeat_d    = rbeat_q;
        rd_en      = 1'b0;
        rd_addr    = ridx_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rid_d      = s_axi_arid;
                    rlen_d     = s_axi_arlen;
                    rburst_d   = s_axi_arburst;
                    rerr_d     = burst_illegal(s_axi_arburst, s_axi_arsize);
                    ridx_d     = s_axi_araddr;
                    rbeat_d    = '0;
                    rd_en      = 1'b1;
                    rd_addr    = s_axi_araddr;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (s_axi_rlast) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rbeat_d = rbeat_q + 8'd1;
                        ridx_d  = next_index(ridx_q, rburst_q);
                        rd_en   = 1'b1;
                        rd_addr = next_index(ridx_q, rburst_q);
                    end
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    // Read FSM state and burst context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            ridx_q     <= '0;
            rid_q      <= '0;
            rlen_q     <= '0;
            rburst_q   <= FIXED;
            rerr_q     <= 1'b0;
            rbeat_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            ridx_q     <= ridx_d;
            rid_q      <= rid_d;
            rlen_q     <= rlen_d;
            rburst_q   <= rburst_d;
            rerr_q     <= rerr_d;
            rbeat_q    <= rbeat_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    csr_regarray u_regarray (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (widx_q),
        .wdata_i (s_axi_wdata),
        .wstrb_i (s_axi_wstrb),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_csr_axi_slave.sv
// ============================================================================
// Module      : tb_csr_axi_slave
// Description : Self-checking bench for csr_axi_slave: vector table of single
//               write/read pairs plus hand sequences for bursts, errors,
//               back-pressure, the busy window and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_axi_slave;

    localparam int         ID_W        = 5;
    localparam int         INIT_CYCLES = 4;
    localparam int         TMO         = 200;
    localparam logic [1:0] B_FIXED     = 2'b00;
    localparam logic [1:0] B_INCR      = 2'b01;
    localparam logic [1:0] B_WRAP      = 2'b10;
    localparam logic [1:0] R_OK        = 2'b00;
    localparam logic [1:0] R_ERR       = 2'b10;
    localparam logic [2:0] SZ_W        = 3'b010;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_axi_awvalid;
    logic [4:0]      s_axi_awaddr;
    logic [ID_W-1:0] s_axi_awid;
    logic [7:0]      s_axi_awlen;
    logic [2:0]      s_axi_awsize;
    logic [1:0]      s_axi_awburst;
    logic            s_axi_awready;
    logic            s_axi_wvalid;
    logic [31:0]     s_axi_wdata;
    logic [3:0]      s_axi_wstrb;
    logic            s_axi_wlast;
    logic            s_axi_wready;
    logic            s_axi_bvalid;
    logic [ID_W-1:0] s_axi_bid;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bready;
    logic            s_axi_arvalid;
    logic [4:0]      s_axi_araddr;
    logic [ID_W-1:0] s_axi_arid;
    logic [7:0]      s_axi_arlen;
    logic [2:0]      s_axi_arsize;
    logic [1:0]      s_axi_arburst;
    logic            s_axi_arready;
    logic            s_axi_rvalid;
    logic [31:0]     s_axi_rdata;
    logic [ID_W-1:0] s_axi_rid;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic            s_axi_rready;
    logic            rsta_busy;
    logic            rstb_busy;

    csr_axi_slave #(
        .ID_W        (ID_W),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awready (s_axi_awready),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arid    (s_axi_arid),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arready (s_axi_arready),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rready  (s_axi_rready),
        .rsta_busy     (rsta_busy),
        .rstb_busy     (rstb_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     data;
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
        logic            last;
    } r_exp_t;

    typedef struct packed {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } b_exp_t;

    typedef struct packed {
        logic [4:0]      addr;
        logic [ID_W-1:0] id;
        logic [31:0]     wdata;
        logic [3:0]      wstrb;
        logic [1:0]      burst;
        logic [2:0]      size;
        logic [1:0]      exp_bresp;
        logic [31:0]     exp_rdata;
    } vec_t;

    r_exp_t      rq[$];
    b_exp_t      bq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];
    logic [31:0] wbuf  [8];
    vec_t        vecs  [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake within %0d cycles, expected one", nm, TMO);
    endtask

    // Response monitor: scoreboard pops plus stability while stalled
    logic             hold_pending = 1'b0;
    logic [31:0]      hold_data;
    logic [ID_W+2:0]  hold_ctl;
    always @(negedge clk) begin
        r_exp_t re;
        b_exp_t be;
        if (hold_pending && rst_n) begin
            chk("r_hold_data", s_axi_rdata, hold_data);
            chk("r_hold_ctl", {s_axi_rresp, s_axi_rid, s_axi_rlast}, hold_ctl);
        end
        hold_pending = rst_n && s_axi_rvalid && !s_axi_rready;
        hold_data    = s_axi_rdata;
        hold_ctl     = {s_axi_rresp, s_axi_rid, s_axi_rlast};
        if (rst_n && s_axi_rvalid && s_axi_rready) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_unexpected: got beat %h expected none", s_axi_rdata);
            end else begin
                re = rq.pop_front();
                chk("r_data", s_axi_rdata, re.data);
                chk("r_ctl", {s_axi_rresp, s_axi_rid, s_axi_rlast}, {re.resp, re.id, re.last});
            end
        end
        if (rst_n && s_axi_bvalid && s_axi_bready) begin
            if (bq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got bresp %0h expected none", s_axi_bresp);
            end else begin
                be = bq.pop_front();
                chk("b_resp_id", {s_axi_bresp, s_axi_bid}, {be.resp, be.id});
            end
        end
    end

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp,
                          input logic [ID_W-1:0] id, input logic last);
        rq.push_back('{data: d, resp: resp, id: id, last: last});
    endtask

    task automatic push_model_read(input logic [4:0] addr, input logic [7:0] len,
                                   input logic [1:0] burst, input logic [ID_W-1:0] id);
        logic [4:0] idx;
        idx = addr;
        for (int b = 0; b <= int'(len); b++) begin
            push_r(model[idx], R_OK, id, b == int'(len));
            if (burst == B_INCR) idx = idx + 5'd1;
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [ID_W-1:0] id,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input int nbeats,
                             input logic [3:0] strb, input logic [1:0] exp_bresp);
        logic [4:0] idx;
        int         t;
        bq.push_back('{resp: exp_bresp, id: id});
        idx = addr;
        for (int b = 0; b < nbeats; b++) begin
            if ((burst == B_FIXED || burst == B_INCR) && size == SZ_W && idx != 5'd0) begin
                for (int k = 0; k < 4; k++) begin
                    if (strb[k]) model[idx][8*k +: 8] = wbuf[b][8*k +: 8];
                end
            end
            if (burst == B_INCR) idx = idx + 5'd1;
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = addr;
        s_axi_awid    = id;
        s_axi_awlen   = len;
        s_axi_awburst = burst;
        s_axi_awsize  = size;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_awready && t < TMO);
        if (!s_axi_awready) timeout("aw_timeout");
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wbuf[b];
            s_axi_wstrb  = strb;
            s_axi_wlast  = (b == nbeats - 1);
            t = 0;
            do begin @(negedge clk); t++; end while (!s_axi_wready && t < TMO);
            if (!s_axi_wready) timeout("w_timeout");
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [ID_W-1:0] id,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size);
        int t;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_arid    = id;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arsize  = size;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_arready && t < TMO);
        if (!s_axi_arready) timeout("ar_timeout");
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < TMO) begin
            @(negedge clk); #1;
            t++;
        end
        if (rq.size() != 0 || bq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d R and %0d B pending, expected 0", rq.size(), bq.size());
            rq.delete();
            bq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy_cnt;
        int   ready_while_busy;
        logic saw_b;

        vecs[0] = '{5'd5,  5'd3,  32'hDEADBEEF, 4'hF, B_INCR,  SZ_W,   R_OK,  32'hDEADBEEF};
        vecs[1] = '{5'd7,  5'd1,  32'hFFFFFFFF, 4'hF, B_INCR,  SZ_W,   R_OK,  32'hFFFFFFFF};
        vecs[2] = '{5'd7,  5'd2,  32'h12345678, 4'h5, B_INCR,  SZ_W,   R_OK,  32'hFF34FF78};
        vecs[3] = '{5'd0,  5'd4,  32'hCAFEF00D, 4'hF, B_INCR,  SZ_W,   R_OK,  32'h00000000};
        vecs[4] = '{5'd9,  5'd5,  32'h11111111, 4'hF, B_WRAP,  SZ_W,   R_ERR, 32'h00000000};
        vecs[5] = '{5'd9,  5'd6,  32'h22222222, 4'hF, B_INCR,  3'b011, R_ERR, 32'h00000000};
        vecs[6] = '{5'd10, 5'd7,  32'hA5A5A5A5, 4'h8, B_FIXED, SZ_W,   R_OK,  32'hA5000000};
        vecs[7] = '{5'd31, 5'd8,  32'h0BADF00D, 4'h0, B_INCR,  SZ_W,   R_OK,  32'h00000000};
        vecs[8] = '{5'd31, 5'd31, 32'h76543210, 4'hF, B_INCR,  SZ_W,   R_OK,  32'h76543210};

        for (int i = 0; i < 32; i++) model[i] = '0;
        rst_n = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0;
        s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
        s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_rready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
        chk("rst_valid",   {s_axi_bvalid, s_axi_rvalid, s_axi_rlast}, 0);
        chk("rst_busy",    {rsta_busy, rstb_busy}, 2'b11);
        chk("rst_payload", {s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid}, 0);
        chk("rst_rdata",   s_axi_rdata, 0);

        // Busy window after release
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy_cnt = 0;
        ready_while_busy = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!rsta_busy) break;
            busy_cnt++;
            if (s_axi_awready || s_axi_arready || s_axi_wready) ready_while_busy++;
        end
        chk("busy_cycles",      busy_cnt, INIT_CYCLES);
        chk("ready_while_busy", ready_while_busy, 0);
        chk("post_busy",        {rsta_busy, rstb_busy, s_axi_awready, s_axi_arready}, 4'b0011);

        // Single-beat vector table
        for (int i = 0; i < 9; i++) begin
            wbuf[0] = vecs[i].wdata;
            axi_write(vecs[i].addr, vecs[i].id, 8'd0, vecs[i].burst, vecs[i].size, 1,
                      vecs[i].wstrb, vecs[i].exp_bresp);
            wait_idle();
            push_r(vecs[i].exp_rdata, R_OK, vecs[i].id, 1'b1);
            axi_read(vecs[i].addr, vecs[i].id, 8'd0, B_INCR, SZ_W);
            wait_idle();
        end

        // INCR burst wrapping 30 -> 31 -> 0 -> 1
        wbuf[0] = 32'hAAAA0001; wbuf[1] = 32'hBBBB0002;
        wbuf[2] = 32'hCCCC0003; wbuf[3] = 32'hDDDD0004;
        axi_write(5'd30, 5'd2, 8'd3, B_INCR, SZ_W, 4, 4'hF, R_OK);
        wait_idle();
        push_r(32'hAAAA0001, R_OK, 5'd2, 1'b0);
        push_r(32'hBBBB0002, R_OK, 5'd2, 1'b0);
        push_r(32'h00000000, R_OK, 5'd2, 1'b0);
        push_r(32'hDDDD0004, R_OK, 5'd2, 1'b1);
        axi_read(5'd30, 5'd2, 8'd3, B_INCR, SZ_W);
        wait_idle();

        // Illegal read burst: two zero beats with SLVERR, storage untouched
        push_r(32'h0, R_ERR, 5'd4, 1'b0);
        push_r(32'h0, R_ERR, 5'd4, 1'b1);
        axi_read(5'd5, 5'd4, 8'd1, B_WRAP, SZ_W);
        wait_idle();
        push_r(32'hDEADBEEF, R_OK, 5'd4, 1'b1);
        axi_read(5'd5, 5'd4, 8'd0, B_INCR, SZ_W);
        wait_idle();

        // Back-pressure: 3 stalled cycles on a 3-beat read
        s_axi_rready = 1'b0;
        push_model_read(5'd5, 8'd2, B_INCR, 5'd6);
        axi_read(5'd5, 5'd6, 8'd2, B_INCR, SZ_W);
        repeat (3) @(posedge clk);
        #1 s_axi_rready = 1'b1;
        wait_idle();

        // Early wlast: SLVERR, the single beat stays written
        wbuf[0] = 32'h0E0E0E0E;
        axi_write(5'd12, 5'd7, 8'd1, B_INCR, SZ_W, 1, 4'hF, R_ERR);
        wait_idle();
        // Late wlast: SLVERR, both beats written
        wbuf[0] = 32'h13131313; wbuf[1] = 32'h14141414;
        axi_write(5'd13, 5'd8, 8'd0, B_INCR, SZ_W, 2, 4'hF, R_ERR);
        wait_idle();
        push_model_read(5'd12, 8'd2, B_INCR, 5'd9);
        axi_read(5'd12, 5'd9, 8'd2, B_INCR, SZ_W);
        wait_idle();

        // FIXED burst: all beats land on one register, last one wins
        wbuf[0] = 32'h20202020; wbuf[1] = 32'h21212121; wbuf[2] = 32'h22222222;
        axi_write(5'd20, 5'd10, 8'd2, B_FIXED, SZ_W, 3, 4'hF, R_OK);
        wait_idle();
        push_r(32'h22222222, R_OK, 5'd11, 1'b0);
        push_r(32'h22222222, R_OK, 5'd11, 1'b1);
        axi_read(5'd20, 5'd11, 8'd1, B_FIXED, SZ_W);
        wait_idle();

        // Reset in the middle of a write burst: no response, storage cleared
        @(posedge clk); #1;
        s_axi_awvalid = 1'b1; s_axi_awaddr = 5'd3; s_axi_awid = 5'd12;
        s_axi_awlen = 8'd3; s_axi_awburst = B_INCR; s_axi_awsize = SZ_W;
        @(negedge clk);
        chk("abort_awready", s_axi_awready, 1'b1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h33333333; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0;
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk);
        chk("abort_in_reset", {s_axi_awready, s_axi_wready, s_axi_bvalid, rsta_busy}, 4'b0001);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_b = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw_b = saw_b | s_axi_bvalid;
        end
        chk("abort_no_bresp", saw_b, 1'b0);
        push_r(32'h0, R_OK, 5'd13, 1'b0);
        push_r(32'h0, R_OK, 5'd13, 1'b0);
        push_r(32'h0, R_OK, 5'd13, 1'b1);
        axi_read(5'd3, 5'd13, 8'd2, B_INCR, SZ_W);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
